comp_mult_res_wr: RTL and testbench
===================================

COMP_MULT_RES_WR -- requirements
Module: comp_mult_res_wr

Interface
- REQ-001 SHALL have parameter DWIDTH, default 8: operand element width; result = 6 bytes of DWIDTH bits each.
- REQ-002 SHALL have parameter SYS_AW, default 16: system/memory address width.
- REQ-003 SHALL have parameter BUF_DEPTH, default 2: result buffer entries, power of 2, >= 2.
- REQ-004 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
- REQ-006 SHALL have port sw_rst, input, 1: synchronous active-high soft reset with the same effect as rst.
- REQ-007 SHALL have port start, input, 1: one-cycle job start pulse from the register file.
- REQ-008 SHALL have port res_ba, input, SYS_AW: result base address, sampled on an accepted start.
- REQ-009 SHALL have port nr_op, input, SYS_AW: number of results to write, sampled on an accepted start.
- REQ-010 SHALL have port res_val, input, 1: multiplier result valid.
- REQ-011 SHALL have port res_rdy, output, 1: block can accept a result.
- REQ-012 SHALL have port res_data, input, 6*DWIDTH: result {xr,yr}.
- REQ-013 SHALL have port mem_ce, output, 1: memory chip enable.
- REQ-014 SHALL have port mem_we, output, 1: memory write enable.
- REQ-015 SHALL have port mem_addr, output, SYS_AW: memory byte address.
- REQ-016 SHALL have port mem_wr_data, output, DWIDTH: memory write byte.
- REQ-017 SHALL have port mem_gnt, input, 1: memory port granted this cycle (shared with the operand fetcher).
- REQ-018 SHALL have port busy, output, 1: a job is in progress.
- REQ-019 SHALL have port done, output, 1: one-cycle job completion pulse.

Function
- REQ-020 SHALL implement states IDLE, RUN, DONE.
- REQ-021 IDLE: a start pulse SHALL capture res_ba and nr_op and move to RUN; start SHALL be ignored in RUN and DONE.
- REQ-022 A start with nr_op = 0 SHALL go from IDLE to DONE and write nothing.
- REQ-023 A result SHALL be accepted into the buffer when res_val & res_rdy on a rising edge.
- REQ-024 res_rdy SHALL be 1 only in RUN, only when the buffer is not full, and only while accepted count < nr_op; results beyond nr_op SHALL never be accepted.
- REQ-025 The buffer head SHALL be written as 6 bytes in order res_data[6*DWIDTH-1 -: DWIDTH] first (MSB first), down to res_data[DWIDTH-1:0] last.
- REQ-026 Byte k of result n SHALL be written to address res_ba + 6*n + k; the address SHALL wrap modulo 2^SYS_AW.
- REQ-027 mem_ce and mem_we SHALL both be 1 whenever the buffer is non-empty in RUN.
- REQ-028 A byte write SHALL complete only in a cycle where mem_ce & mem_gnt; while mem_gnt = 0, mem_addr and mem_wr_data SHALL hold their values.
- REQ-029 A byte write SHALL complete in the same cycle as mem_ce & mem_gnt; at most one byte per cycle; after the 6th byte the entry SHALL be popped.
- REQ-030 Push and pop in the same cycle SHALL leave the occupancy unchanged.
- REQ-031 Minimum latency SHALL be: first byte on the memory bus the cycle after acceptance.
- REQ-032 Sustained throughput with mem_gnt = 1 SHALL be 6 cycles per result.
- REQ-033 When nr_op results have been written, RUN SHALL go to DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
- REQ-034 busy SHALL be 1 in RUN and DONE.
- REQ-035 When mem_ce = 0, mem_addr and mem_wr_data SHALL be 0.

Reset
- REQ-036 rst or sw_rst, including mid-job, SHALL discard all buffered data and return to IDLE.
- REQ-037 During and after reset: res_rdy = 0, mem_ce = 0, mem_we = 0, mem_addr = 0, mem_wr_data = 0, busy = 0, done = 0, counters and buffer pointers = 0.

Verification
- REQ-038 Basic job: start with res_ba = 300, nr_op = 1, mem_gnt = 1; result 48'h0102_0304_0506 -> bytes 01..06 written to addresses 300..305 on consecutive cycles, then done for one cycle.
- REQ-039 Back-to-back: res_ba = 300, nr_op = 10, res_val held 1, mem_gnt = 1 -> 60 consecutive writes to 300..359, res_rdy deasserts whenever the buffer is full, done follows the last write.
- REQ-040 Grant stall: mem_gnt = 0 for 5 cycles during byte 2 -> address and data held, no byte skipped or duplicated, memory contents still correct.
- REQ-041 Boundaries: start with nr_op = 0 -> done with no memory access; res_ba = 16'hFFFE, nr_op = 1 -> writes to FFFE, FFFF, 0000..0003.
- REQ-042 Overflow and restart: res_val held after nr_op results -> res_rdy stays 0; a start pulse while busy -> ignored.
- REQ-043 Mid-job reset: sw_rst after 3 bytes -> outputs immediately at reset values, no further writes; a subsequent start runs a clean job.

Source files
------------

// File: rtl/comp_mult_res_wr.sv
// comp_mult_res_wr
// ----------------
// Takes 6*DWIDTH-bit multiplier results ({xr,yr}) and writes each one to
// memory as six DWIDTH-bit bytes, most significant byte first. Result n
// goes to byte addresses res_ba + 6*n .. res_ba + 6*n + 5, wrapping modulo
// 2^SYS_AW. A small FIFO (BUF_DEPTH entries) decouples result arrival from
// memory grants, so a new result can be accepted while the previous one is
// still being written.
//
// Handshakes:
//   result side : a result transfers on a rising edge where res_val & res_rdy.
//                 res_val may be held; res_rdy never rises beyond nr_op.
//   memory side : mem_ce/mem_we request a byte write; the byte completes on
//                 the edge where mem_ce & mem_gnt. While mem_gnt is low the
//                 address and data are held.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sw_rst            synchronous active-high soft reset (same effect as rst)
//   start             one-cycle job start (honoured only in IDLE)
//   res_ba, nr_op     result base address / result count, sampled on start
//   res_val, res_rdy  result handshake
//   res_data          result {xr,yr}
//   mem_ce, mem_we    memory chip/write enable
//   mem_addr          memory byte address (0 when mem_ce = 0)
//   mem_wr_data       memory write byte   (0 when mem_ce = 0)
//   mem_gnt           memory port granted this cycle
//   busy, done        job in progress / one-cycle completion pulse
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)

module comp_mult_res_wr #(
    parameter int DWIDTH    = 8,
    parameter int SYS_AW    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst,
    input  logic                start,
    input  logic [SYS_AW-1:0]   res_ba,
    input  logic [SYS_AW-1:0]   nr_op,
    input  logic                res_val,
    output logic                res_rdy,
    input  logic [6*DWIDTH-1:0] res_data,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [SYS_AW-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_wr_data,
    input  logic                mem_gnt,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    localparam int RW = 6 * DWIDTH;
    localparam int PW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYS_AW-1:0] addr_q, addr_d;        // address of the byte being written
    logic [SYS_AW-1:0] nr_op_q, nr_op_d;
    logic [SYS_AW-1:0] acc_cnt_q, acc_cnt_d;  // results accepted this job
    logic [SYS_AW-1:0] wr_cnt_q, wr_cnt_d;    // results fully written this job
    logic [2:0]        byte_idx_q, byte_idx_d;
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;

    logic [RW-1:0]     buf_mem [BUF_DEPTH];

    logic              buf_full;
    logic              buf_empty;
    logic              in_run;
    logic              push;
    logic              byte_done;
    logic [RW-1:0]     head;
    logic [RW-1:0]     head_shift;

    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // sw_rst masks all outputs combinationally so that they already show
    // reset values in the cycle the soft reset is asserted.
    assign in_run  = (state_q == S_RUN) && !sw_rst;
    assign res_rdy = in_run && !buf_full && (acc_cnt_q < nr_op_q);
    assign mem_ce  = in_run && !buf_empty;
    assign mem_we  = mem_ce;
    assign busy    = (state_q != S_IDLE) && !sw_rst;
    assign done    = (state_q == S_DONE) && !sw_rst;
    assign dbg_state = state_q;

    assign push      = res_val && res_rdy;
    assign byte_done = mem_ce && mem_gnt;

    // Current byte: shift the head entry left so the selected byte sits at
    // the top, then take the top DWIDTH bits (byte 0 is the MSB).
    assign head       = buf_mem[rd_ptr_q[PW-1:0]];
    assign head_shift = head << (32'(byte_idx_q) * DWIDTH);

    assign mem_addr    = mem_ce ? addr_q : '0;
    assign mem_wr_data = mem_ce ? head_shift[RW-1 -: DWIDTH] : '0;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nr_op_d    = nr_op_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        byte_idx_d = byte_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = res_ba;
                    nr_op_d    = nr_op;
                    acc_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    byte_idx_d = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    state_d    = (nr_op == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    wr_ptr_d  = wr_ptr_q + (PW+1)'(1);
                    acc_cnt_d = acc_cnt_q + SYS_AW'(1);
                end
                if (byte_done) begin
                    addr_d = addr_q + SYS_AW'(1);
                    if (byte_idx_q == 3'd5) begin
                        byte_idx_d = '0;
                        rd_ptr_d   = rd_ptr_q + (PW+1)'(1);
                        wr_cnt_d   = wr_cnt_q + SYS_AW'(1);
                        if (wr_cnt_q + SYS_AW'(1) == nr_op_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sw_rst) begin
            state_d    = S_IDLE;
            addr_d     = '0;
            nr_op_d    = '0;
            acc_cnt_d  = '0;
            wr_cnt_d   = '0;
            byte_idx_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            nr_op_q    <= '0;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            byte_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nr_op_q    <= nr_op_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            byte_idx_q <= byte_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Buffer storage needs no reset: an entry is only read after it has
    // been pushed, and the pointers are cleared by either reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_q[PW-1:0]] <= res_data;
        end
    end

endmodule

// File: tb/tb_comp_mult_res_wr.sv
// tb_comp_mult_res_wr
// -------------------
// Directed job sequence with randomized data/handshakes for comp_mult_res_wr.
// The reference model turns every accepted result into its six expected
// (address, byte) writes and checks memory bus writes against that queue.

module tb_comp_mult_res_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst;
    logic        start;
    logic [15:0] res_ba;
    logic [15:0] nr_op;
    logic        res_val;
    logic        res_rdy;
    logic [47:0] res_data;
    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_gnt;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    comp_mult_res_wr #(.DWIDTH(8), .SYS_AW(16), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .start(start),
        .res_ba(res_ba), .nr_op(nr_op), .res_val(res_val), .res_rdy(res_rdy),
        .res_data(res_data), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_gnt(mem_gnt),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam int M_HELD  = 0;
    localparam int M_RAND  = 1;
    localparam int M_STALL = 2;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [23:0] exp_q[$];        // {addr, byte} of pending expected writes
    logic [15:0] base_m;
    int          nr_m;
    int          acc_m;
    int          wr_cnt_m;
    int          done_cnt;
    int          done_cyc;
    int          first_acc_cyc;
    int          first_wr_cyc;
    int          last_wr_cyc;
    int          stall_seen;
    int          bp_cnt;
    int          cyc = 0;
    bit          accepted_flag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample/check outputs at the falling edge, then
    // return just after the next rising edge so the caller can drive inputs.
    task automatic cycle();
        logic [23:0] e;
        @(negedge clk);
        cyc++;
        if (mem_ce) begin
            check("we_with_ce", mem_we, 1);
        end else begin
            check("addr_idle", mem_addr, 0);
            check("data_idle", mem_wr_data, 0);
        end
        if (mem_ce || res_rdy) check("busy_active", busy, 1);
        if (mem_ce && !mem_gnt) begin
            stall_seen++;
            if (exp_q.size() != 0) check("stall_hold", {mem_addr, mem_wr_data}, exp_q[0]);
        end
        if (mem_ce && mem_gnt) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("write", {mem_addr, mem_wr_data}, e);
            end
            wr_cnt_m++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (res_rdy) check("rdy_within_nr", acc_m < nr_m, 1);
        if (busy && !res_rdy && acc_m < nr_m) bp_cnt++;
        if (res_val && res_rdy) begin
            for (int k = 0; k < 6; k++) begin
                exp_q.push_back({16'(int'(base_m) + 6 * acc_m + k), res_data[47 - 8 * k -: 8]});
            end
            acc_m++;
            accepted_flag = 1'b1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_writes", wr_cnt_m, 6 * nr_m);
            check("done_busy", busy, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input logic [15:0] base, input int nr);
        exp_q.delete();
        base_m = base; nr_m = nr; acc_m = 0; wr_cnt_m = 0;
        done_cnt = 0; done_cyc = -1; first_acc_cyc = -1;
        first_wr_cyc = -1; last_wr_cyc = -1; stall_seen = 0; bp_cnt = 0;
        accepted_flag = 1'b0;
    endtask

    task automatic run_job(input logic [15:0] base, input logic [15:0] nr,
                           input int mode, input logic [47:0] d0);
        int n;
        int stall_left;
        model_clear(base, int'(nr));
        stall_left = 5;
        res_data = d0;
        start = 1'b1; res_ba = base; nr_op = nr; res_val = 1'b0; mem_gnt = 1'b1;
        cycle();
        start = 1'b0; res_ba = 16'($urandom()); nr_op = 16'($urandom());
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            if (accepted_flag) res_data = 48'({$urandom(), $urandom()});
            accepted_flag = 1'b0;
            case (mode)
                M_HELD: begin
                    res_val = 1'b1; mem_gnt = 1'b1;
                end
                M_RAND: begin
                    res_val = ($urandom_range(0, 2) != 0);
                    mem_gnt = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    res_val = 1'b1;
                    if (wr_cnt_m == 1 && stall_left > 0) begin
                        mem_gnt = 1'b0;
                        stall_left--;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
            endcase
            // a start arriving mid-job must be ignored
            start = (n == 3);
            if (start) begin
                res_ba = 16'h1234; nr_op = 16'd7;
            end
            cycle();
            n++;
        end
        start = 1'b0; res_val = 1'b0; mem_gnt = 1'b1;
        check("job_timeout", done_cnt != 0, 1);
        check("job_writes", wr_cnt_m, 6 * int'(nr));
        check("job_accepts", acc_m, int'(nr));
        check("job_exp_empty", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        repeat (3) cycle();
        check("done_once", done_cnt, 1);
        if (nr != 0) check("done_after_last", done_cyc, last_wr_cyc + 1);
    endtask

    initial begin
        rst = 1'b1; sw_rst = 1'b0; start = 1'b0; res_ba = '0; nr_op = '0;
        res_val = 1'b0; res_data = '0; mem_gnt = 1'b1;
        model_clear(16'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", res_rdy, 0);
        check("rst_ce", mem_ce, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        repeat (2) cycle();

        // basic single result
        run_job(16'd300, 16'd1, M_HELD, 48'h0102_0304_0506);
        check("latency", first_wr_cyc, first_acc_cyc + 1);

        // back-to-back: 60 writes with no gaps, back-pressure when full
        run_job(16'd300, 16'd10, M_HELD, 48'(({$urandom(), $urandom()})));
        check("b2b_span", last_wr_cyc - first_wr_cyc, 59);
        check("b2b_backpressure", bp_cnt > 0, 1);

        // grant stall during the second byte
        run_job(16'd500, 16'd3, M_STALL, 48'hA1B2_C3D4_E5F6);
        check("stall_cycles", stall_seen, 5);

        // zero-length job and address wrap
        run_job(16'd100, 16'd0, M_HELD, 48'h0);
        check("nr0_no_write", first_wr_cyc, -1);
        run_job(16'hFFFE, 16'd1, M_HELD, 48'h1122_3344_5566);

        // random handshakes
        for (int j = 0; j < 4; j++) begin
            run_job(16'($urandom()), 16'($urandom_range(1, 6)), M_RAND,
                    48'({$urandom(), $urandom()}));
        end

        // soft reset after three bytes
        model_clear(16'd700, 2);
        res_data = 48'hDEAD_BEEF_0042;
        start = 1'b1; res_ba = 16'd700; nr_op = 16'd2; mem_gnt = 1'b1;
        cycle();
        start = 1'b0;
        for (int n = 0; n < 50 && wr_cnt_m < 3; n++) begin
            res_val = 1'b1;
            cycle();
        end
        check("pre_swrst_writes", wr_cnt_m, 3);
        sw_rst = 1'b1;
        #1;
        check("swrst_ce", mem_ce, 0);
        check("swrst_addr", mem_addr, 0);
        check("swrst_data", mem_wr_data, 0);
        check("swrst_rdy", res_rdy, 0);
        check("swrst_busy", busy, 0);
        cycle();
        sw_rst = 1'b0;
        model_clear(16'd0, 0);
        repeat (5) cycle();
        res_val = 1'b0;
        check("post_swrst_writes", wr_cnt_m, 0);
        check("post_swrst_state", dbg_state, 0);
        run_job(16'd800, 16'd2, M_RAND, 48'h0A0B_0C0D_0E0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
